// File: rtl/uart_rx_ctrl_if.sv
// Wishbone classic register bus between the CPU side and the UART receive controller.
// dbg_state mirrors the slave's access FSM so checkers can bind to it.
interface uart_rx_ctrl_if;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [1:0]  adr;
   logic [31:0] dat_i;
   logic [31:0] dat_o;
   logic        ack;
   logic        dbg_state;

   // A transfer is offered while cyc&stb are high and completes in the cycle
   // ack is high; dat_o is meaningful only in that cycle and reads 0 otherwise.
   modport master (
      output cyc, stb, we, adr, dat_i,
      input  dat_o, ack, dbg_state
   );

   modport slave (
      input  cyc, stb, we, adr, dat_i,
      output dat_o, ack, dbg_state
   );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: buffers deserialized bytes in a FIFO and exposes
// DATA/COUNT/STATUS/CTRL registers on a Wishbone classic slave port.
module uart_rx_ctrl #(
   parameter int DEPTH     = 256,
   parameter int IRQ_LEVEL = 1
) (
   input  logic           clk,
   input  logic           rst,
   uart_rx_ctrl_if.slave  wb,
   input  logic           rx_valid,
   input  logic [7:0]     rx_data,
   input  logic           rx_frame_err,
   output logic           rx_en,
   output logic           irq
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic {ST_IDLE, ST_ACK} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          overrun_q, overrun_d;
   logic          frame_err_q, frame_err_d;
   logic          enable_q, enable_d;
   logic          irq_q, irq_d;
   logic [7:0]    mem [DEPTH];

   logic          ack;
   logic          access;
   logic          full, empty;
   logic          pop, push_req, push_ok, flush;
   logic          status_wr, ctrl_wr;
   logic          ovr_set, ferr_set;
   logic [31:0]   rdata;
   logic          unused_dat_i;

   assign unused_dat_i = ^wb.dat_i[31:2];

   // Access FSM: every accepted strobe costs exactly one ACK cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (wb.cyc && wb.stb) state_d = ST_ACK;
         ST_ACK:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign ack          = (state_q == ST_ACK);
   assign wb.ack       = ack;
   assign wb.dbg_state = state_q;

   assign access    = ack && wb.cyc && wb.stb;
   assign full      = (count_q == CW'(DEPTH));
   assign empty     = (count_q == '0);
   assign pop       = access && !wb.we && (wb.adr == 2'd0) && !empty;
   assign status_wr = access && wb.we && (wb.adr == 2'd2);
   assign ctrl_wr   = access && wb.we && (wb.adr == 2'd3);
   assign flush     = ctrl_wr && wb.dat_i[1];
   assign push_req  = rx_valid && enable_q;
   // A pop on the same edge frees a slot, so a full FIFO can still accept.
   assign push_ok   = push_req && (!full || pop) && !flush;
   assign ovr_set   = push_req && full && !pop && !flush;
   assign ferr_set  = push_req && rx_frame_err;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      enable_d    = enable_q;
      overrun_d   = overrun_q;
      frame_err_d = frame_err_q;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(push_ok) - CW'(pop);
      end

      if (ctrl_wr) enable_d = wb.dat_i[0];

      // Clear first, then set, so a coincident event wins over W1C.
      if (status_wr && wb.dat_i[0]) overrun_d   = 1'b0;
      if (status_wr && wb.dat_i[1]) frame_err_d = 1'b0;
      if (ovr_set)  overrun_d   = 1'b1;
      if (ferr_set) frame_err_d = 1'b1;

      irq_d = (count_q >= CW'(IRQ_LEVEL)) || overrun_q || frame_err_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
         enable_q    <= 1'b0;
         irq_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
         enable_q    <= enable_d;
         irq_q       <= irq_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_q] <= rx_data;
   end

   always_comb begin
      rdata = '0;
      case (wb.adr)
         2'd0:    if (!empty) rdata[7:0] = mem[rd_ptr_q];
         2'd1:    rdata[CW-1:0] = count_q;
         2'd2:    rdata[3:0] = {full, empty, frame_err_q, overrun_q};
         default: rdata[0] = enable_q;
      endcase
   end

   assign wb.dat_o = ack ? rdata : 32'h0;
   assign rx_en    = enable_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed register scenarios plus a
// randomized push/pop run against a queue-based reference model.
module tb_uart_rx_ctrl;
   localparam int DEPTH     = 256;
   localparam int IRQ_LEVEL = 1;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = 8'h0;
   logic       rx_frame_err = 1'b0;
   logic       rx_en;
   logic       irq;

   uart_rx_ctrl_if wb ();

   uart_rx_ctrl #(.DEPTH(DEPTH), .IRQ_LEVEL(IRQ_LEVEL)) dut (
      .clk          (clk),
      .rst          (rst),
      .wb           (wb),
      .rx_valid     (rx_valid),
      .rx_data      (rx_data),
      .rx_frame_err (rx_frame_err),
      .rx_en        (rx_en),
      .irq          (irq)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q[$];
   logic       m_ovr = 1'b0;
   logic       m_ferr = 1'b0;
   logic       m_en = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [1:0] adr);
      logic [31:0] v;
      v = 32'h0;
      case (adr)
         2'd0: if (exp_q.size() > 0) v[7:0] = exp_q[0];
         2'd1: v = 32'(exp_q.size());
         2'd2: v[3:0] = {exp_q.size() == DEPTH, exp_q.size() == 0, m_ferr, m_ovr};
         default: v[0] = m_en;
      endcase
      return v;
   endfunction

   // Received byte arriving on an edge where any pop of that edge already happened.
   task automatic model_rx(input logic [7:0] b, input logic fe, input logic en, input logic fl);
      if (!en) return;
      if (fe) m_ferr = 1'b1;
      if (fl) return;
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else m_ovr = 1'b1;
   endtask

   task automatic rx_push(input logic [7:0] b, input logic fe);
      @(negedge clk);
      rx_valid = 1'b1; rx_data = b; rx_frame_err = fe;
      @(negedge clk);
      rx_valid = 1'b0; rx_frame_err = 1'b0;
      model_rx(b, fe, m_en, 1'b0);
   endtask

   task automatic wb_acc(input string tag, input logic we, input logic [1:0] adr,
                         input logic [31:0] wd, input logic co, input logic [7:0] cb,
                         input logic cfe);
      logic [31:0] exp_rd;
      logic        en_old;
      logic        fl;
      @(negedge clk);
      wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = we; wb.adr = adr; wb.dat_i = wd;
      chk({tag, "_ack_pre"}, 32'(wb.ack), 32'd0);
      exp_rd = model_read(adr);
      @(negedge clk);
      chk({tag, "_ack"}, 32'(wb.ack), 32'd1);
      if (!we) chk({tag, "_rd"}, wb.dat_o, exp_rd);
      if (co) begin
         rx_valid = 1'b1; rx_data = cb; rx_frame_err = cfe;
      end
      @(negedge clk);
      wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
      rx_valid = 1'b0; rx_frame_err = 1'b0;
      chk({tag, "_ack_post"}, {31'h0, wb.ack} | wb.dat_o, 32'd0);
      en_old = m_en;
      fl = we && adr == 2'd3 && wd[1];
      if (we && adr == 2'd2) begin
         if (wd[0]) m_ovr = 1'b0;
         if (wd[1]) m_ferr = 1'b0;
      end
      if (!we && adr == 2'd0 && exp_q.size() > 0) void'(exp_q.pop_front());
      if (fl) exp_q.delete();
      if (we && adr == 2'd3) m_en = wd[0];
      if (co) model_rx(cb, cfe, en_old, fl);
   endtask

   task automatic rd(input string tag, input logic [1:0] adr);
      wb_acc(tag, 1'b0, adr, 32'h0, 1'b0, 8'h0, 1'b0);
   endtask

   task automatic wr(input string tag, input logic [1:0] adr, input logic [31:0] wd);
      wb_acc(tag, 1'b1, adr, wd, 1'b0, 8'h0, 1'b0);
   endtask

   task automatic chk_irq(input string tag);
      @(negedge clk);
      chk(tag, 32'(irq), 32'((exp_q.size() >= IRQ_LEVEL) || m_ovr || m_ferr));
   endtask

   initial begin
      #200000000;
      $display("FAIL watchdog expired");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1);
   end

   initial begin
      wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0; wb.adr = 2'd0; wb.dat_i = 32'h0;
      #1;
      chk("rst_out", {wb.dat_o[29:0], wb.ack, rx_en}, 32'h0);
      chk("rst_irq", 32'(irq), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b1;

      // Disabled receiver ignores bytes.
      rx_push(8'h55, 1'b1);
      rd("dis_count", 2'd1);
      rd("dis_status", 2'd2);

      wr("en", 2'd3, 32'h1);
      chk("rx_en_on", 32'(rx_en), 32'd1);
      rx_push(8'h41, 1'b0);
      rx_push(8'h42, 1'b0);
      chk_irq("irq_two");
      rd("data0", 2'd0);
      rd("data1", 2'd0);
      rd("count_empty", 2'd1);
      rd("status_empty", 2'd2);
      rd("data_empty", 2'd0);
      rd("count_empty2", 2'd1);
      chk_irq("irq_empty");

      // Overfill by one.
      for (int i = 0; i <= DEPTH; i++) rx_push(8'($urandom), 1'b0);
      rd("count_full", 2'd1);
      rd("status_ovr", 2'd2);
      chk_irq("irq_ovr");
      wr("w1c_ovr", 2'd2, 32'h1);
      rd("status_clr", 2'd2);
      // Pop and push together on a full FIFO.
      wb_acc("pop_push", 1'b0, 2'd0, 32'h0, 1'b1, 8'hA5, 1'b0);
      rd("count_full2", 2'd1);
      rd("status_noovr", 2'd2);
      for (int i = 0; i < DEPTH; i++) rd("drain", 2'd0);
      rd("count_drained", 2'd1);

      // Flush with a coincident byte carrying a frame error.
      for (int i = 0; i < 3; i++) rx_push(8'($urandom), 1'b0);
      wb_acc("flush", 1'b1, 2'd3, 32'h3, 1'b1, 8'h77, 1'b1);
      rd("count_flush", 2'd1);
      rd("status_flush", 2'd2);
      rd("ctrl_flush", 2'd3);
      wb_acc("w1c_setwins", 1'b1, 2'd2, 32'h2, 1'b1, 8'h66, 1'b1);
      rd("status_setwins", 2'd2);
      wr("w1c_all", 2'd2, 32'h3);
      rd("status_allclr", 2'd2);
      wr("disable", 2'd3, 32'h0);
      chk("rx_en_off", 32'(rx_en), 32'd0);
      rx_push(8'h99, 1'b1);
      rd("count_dis", 2'd1);
      rd("status_dis", 2'd2);

      // Randomized traffic with interleaved reads; wraps the pointers.
      wr("en2", 2'd3, 32'h1);
      for (int i = 0; i < 255; i++) begin
         rx_push(8'($urandom), ($urandom_range(0, 15) == 0));
         if ($urandom_range(0, 2) != 0) rd("rnd_data", 2'd0);
         if ($urandom_range(0, 7) == 0) rd("rnd_count", 2'd1);
         if ($urandom_range(0, 7) == 0) rd("rnd_status", 2'd2);
      end
      chk_irq("irq_rnd");
      while (exp_q.size() > 0) rd("rnd_drain", 2'd0);
      rd("rnd_count_end", 2'd1);

      // Reset during the ACK cycle.
      @(negedge clk);
      wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b0; wb.adr = 2'd1;
      @(posedge clk);
      #1;
      chk("mid_ack", 32'(wb.ack), 32'd1);
      rst = 1'b0;
      #1;
      chk("mid_rst_out", {wb.dat_o[29:0], wb.ack, rx_en}, 32'h0);
      chk("mid_rst_irq", 32'(irq), 32'd0);
      wb.cyc = 1'b0; wb.stb = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      m_ovr = 1'b0; m_ferr = 1'b0; m_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_rst_noack", 32'(wb.ack), 32'd0);
      end
      rd("post_count", 2'd1);
      rd("post_status", 2'd2);
      rd("post_ctrl", 2'd3);
      wr("post_en", 2'd3, 32'h1);
      rx_push(8'h3C, 1'b0);
      rd("post_data", 2'd0);
      chk_irq("post_irq");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
